act_row_feeder: RTL and testbench

Activation dispatcher that sits directly upstream of the superblock row and drives each row's activation write port (act_data_in / act_data_in_vld / act_data_in_req). It accepts one stream of packed activation pairs from the global activation buffer and, per job, either broadcasts every beat to all selected rows or distributes consecutive blocks of beats row by row. Each row has a small FIFO, so one stalled row does not corrupt the others. A job is started by the controller, and completion is reported with a done pulse.

---
 rtl/act_row_feeder.sv | 190 +++++++++++++++++++
 tb/tb_act_row_feeder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/act_row_feeder.sv
// Activation dispatcher feeding the superblock rows: broadcasts or distributes an
// incoming beat stream into per-row FIFOs and reports job completion with a done pulse.
module act_row_feeder #(
  parameter int N_ROW      = 3,
  parameter int WID_ACT    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int WID_LEN    = 10
) (
  input  logic                         clk_l,
  input  logic                         rst,
  input  logic                         cfg_start,
  input  logic                         cfg_mode,
  input  logic [N_ROW-1:0]             cfg_row_mask,
  input  logic [WID_LEN-1:0]           cfg_len,
  input  logic [2*WID_ACT-1:0]         in_data,
  input  logic                         in_vld,
  output logic                         in_rdy,
  output logic [2*WID_ACT*N_ROW-1:0]   act_data_in,
  output logic [N_ROW-1:0]             act_data_in_vld,
  input  logic [N_ROW-1:0]             act_data_in_req,
  output logic                         busy,
  output logic                         done
);

  localparam int BEAT_W = 2 * WID_ACT;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ROW_W  = (N_ROW > 1) ? $clog2(N_ROW) : 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t             state, state_nxt;
  logic               done_nxt;
  logic               mode_q;
  logic [N_ROW-1:0]   mask_q;
  logic [WID_LEN-1:0] len_q;
  logic [WID_LEN-1:0] beat_cnt;
  logic [WID_LEN-1:0] row_cnt;
  logic [ROW_W-1:0]   cur_row;
  logic [ROW_W-1:0]   next_row;
  logic [ROW_W-1:0]   first_row;
  logic               has_next;
  logic               accept;
  logic               row_last;

  logic [BEAT_W-1:0]  mem    [N_ROW][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr [N_ROW];
  logic [PTR_W-1:0]   rd_ptr [N_ROW];
  logic [CNT_W-1:0]   occ    [N_ROW];
  logic [N_ROW-1:0]   full, empty, push, pop, empty_nxt;

  always_comb begin
    full      = '0;
    empty     = '0;
    pop       = '0;
    empty_nxt = '0;
    for (int r = 0; r < N_ROW; r++) begin
      full[r]      = (occ[r] == CNT_W'(FIFO_DEPTH));
      empty[r]     = (occ[r] == '0);
      pop[r]       = !empty[r] && act_data_in_req[r];
      empty_nxt[r] = empty[r] || ((occ[r] == CNT_W'(1)) && pop[r]);
    end
  end

  assign act_data_in_vld = ~empty;
  assign busy            = (state != IDLE);

  // Empty rows present zero so the data bus is defined without resetting storage.
  always_comb begin
    act_data_in = '0;
    for (int r = 0; r < N_ROW; r++)
      if (!empty[r]) act_data_in[r*BEAT_W +: BEAT_W] = mem[r][rd_ptr[r]];
  end

  always_comb begin
    in_rdy = 1'b0;
    if (state == FEED) begin
      if (!mode_q) in_rdy = ((full & mask_q) == '0);
      else         in_rdy = !full[cur_row];
    end
  end

  assign accept   = in_vld && in_rdy;
  assign row_last = (row_cnt == len_q - WID_LEN'(1));

  always_comb begin
    push = '0;
    for (int r = 0; r < N_ROW; r++)
      push[r] = accept && (mode_q ? (cur_row == ROW_W'(r)) : mask_q[r]);
  end

  // Scanning downward leaves the lowest qualifying row selected.
  always_comb begin
    next_row  = cur_row;
    has_next  = 1'b0;
    first_row = '0;
    for (int r = N_ROW - 1; r >= 0; r--) begin
      if (mask_q[r] && (ROW_W'(r) > cur_row)) begin
        next_row = ROW_W'(r);
        has_next = 1'b1;
      end
      if (cfg_row_mask[r]) first_row = ROW_W'(r);
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          if ((cfg_row_mask != '0) && (cfg_len != '0)) state_nxt = FEED;
          else                                         done_nxt  = 1'b1;
        end
      end
      FEED: begin
        if (accept) begin
          if (!mode_q && (beat_cnt == len_q - WID_LEN'(1))) state_nxt = DRAIN;
          if (mode_q && row_last && !has_next)             state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (&empty_nxt) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_l) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      mode_q   <= 1'b0;
      mask_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      row_cnt  <= '0;
      cur_row  <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (state == IDLE && cfg_start) begin
        mode_q   <= cfg_mode;
        mask_q   <= cfg_row_mask;
        len_q    <= cfg_len;
        beat_cnt <= '0;
        row_cnt  <= '0;
        cur_row  <= first_row;
      end else if (state == FEED && accept) begin
        if (!mode_q) begin
          beat_cnt <= beat_cnt + WID_LEN'(1);
        end else if (row_last) begin
          row_cnt <= '0;
          cur_row <= next_row;
        end else begin
          row_cnt <= row_cnt + WID_LEN'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_l) begin
    if (rst) begin
      for (int r = 0; r < N_ROW; r++) begin
        wr_ptr[r] <= '0;
        rd_ptr[r] <= '0;
        occ[r]    <= '0;
      end
    end else begin
      for (int r = 0; r < N_ROW; r++) begin
        if (push[r]) wr_ptr[r] <= wr_ptr[r] + PTR_W'(1);
        if (pop[r])  rd_ptr[r] <= rd_ptr[r] + PTR_W'(1);
        case ({push[r], pop[r]})
          2'b10:   occ[r] <= occ[r] + CNT_W'(1);
          2'b01:   occ[r] <= occ[r] - CNT_W'(1);
          default: occ[r] <= occ[r];
        endcase
      end
    end
  end

  always_ff @(posedge clk_l) begin
    for (int r = 0; r < N_ROW; r++)
      if (push[r]) mem[r][wr_ptr[r]] <= in_data;
  end

endmodule

// File: tb/tb_act_row_feeder.sv
// Directed self-checking bench for act_row_feeder: per-row expected beat queues are
// filled by hand for each job and consumed as rows pop.
module tb_act_row_feeder;
  localparam int N_ROW   = 3;
  localparam int BW      = 32;
  localparam int WID_LEN = 10;
  localparam logic [31:0] BASE = 32'hC0DE_0000;

  logic                  clk_l = 1'b0;
  logic                  rst;
  logic                  cfg_start;
  logic                  cfg_mode;
  logic [N_ROW-1:0]      cfg_row_mask;
  logic [WID_LEN-1:0]    cfg_len;
  logic [BW-1:0]         in_data;
  logic                  in_vld;
  logic                  in_rdy;
  logic [BW*N_ROW-1:0]   act_data_in;
  logic [N_ROW-1:0]      act_data_in_vld;
  logic [N_ROW-1:0]      act_data_in_req;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int src_idx, n_accept, first_acc, last_acc, last_pop, done_cyc, busy_gap;
  logic [N_ROW-1:0] vld_seen;
  logic [31:0] exp_q [N_ROW][$];

  act_row_feeder dut (
    .clk_l           (clk_l),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_mode        (cfg_mode),
    .cfg_row_mask    (cfg_row_mask),
    .cfg_len         (cfg_len),
    .in_data         (in_data),
    .in_vld          (in_vld),
    .in_rdy          (in_rdy),
    .act_data_in     (act_data_in),
    .act_data_in_vld (act_data_in_vld),
    .act_data_in_req (act_data_in_req),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk_l = ~clk_l;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accounts for transfers at the coming edge, then advances to 1 time unit past it.
  task automatic tick();
    logic [31:0] want;
    if (in_vld && in_rdy) begin
      if (n_accept == 0) first_acc = cyc;
      last_acc = cyc;
      n_accept++;
      src_idx++;
    end
    for (int r = 0; r < N_ROW; r++) begin
      if (act_data_in_vld[r] === 1'b1) vld_seen[r] = 1'b1;
      if (act_data_in_vld[r] && act_data_in_req[r]) begin
        last_pop = cyc;
        check($sformatf("pop_expected_r%0d", r), 64'(exp_q[r].size() != 0), 64'd1);
        if (exp_q[r].size() != 0) begin
          want = exp_q[r].pop_front();
          check($sformatf("pop_data_r%0d", r), 64'(act_data_in[r*BW +: BW]), 64'(want));
        end
      end
    end
    @(posedge clk_l);
    #1;
    cyc++;
    in_data = BASE + 32'(src_idx);
  endtask

  task automatic start_job(input logic mode, input logic [N_ROW-1:0] mask, input logic [WID_LEN-1:0] len);
    src_idx   = 0;
    n_accept  = 0;
    first_acc = -1;
    last_acc  = -1;
    last_pop  = -1;
    done_cyc  = -1;
    busy_gap  = 0;
    vld_seen  = '0;
    in_data   = BASE;
    cfg_mode     = mode;
    cfg_row_mask = mask;
    cfg_len      = len;
    cfg_start    = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic expect_row(input int r, input int first, input int n);
    for (int i = 0; i < n; i++) exp_q[r].push_back(BASE + 32'(first + i));
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      if (busy !== 1'b1) busy_gap++;
      tick();
      n++;
    end
    check("done_within_budget", 64'(done), 64'd1);
    done_cyc = cyc;
    check("busy_low_with_done", 64'(busy), 64'd0);
    check("busy_held_during_job", 64'(busy_gap), 64'd0);
  endtask

  task automatic check_drained(input string tag);
    for (int r = 0; r < N_ROW; r++)
      check($sformatf("%s_left_r%0d", tag, r), 64'(exp_q[r].size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_mode = 1'b0;
    cfg_row_mask = '0;
    cfg_len = '0;
    in_data = '0;
    in_vld = 1'b0;
    act_data_in_req = '0;
    tick();
    tick();
    check("rst_in_rdy", 64'(in_rdy), 64'd0);
    check("rst_vld", 64'(act_data_in_vld), 64'd0);
    check("rst_data_zero", 64'(act_data_in === '0), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] broadcast mask=111 len=5");
    in_vld = 1'b1;
    act_data_in_req = 3'b111;
    start_job(1'b0, 3'b111, 10'd5);
    for (int r = 0; r < N_ROW; r++) expect_row(r, 0, 5);
    check("bc_busy_after_start", 64'(busy), 64'd1);
    check("bc_rdy_after_start", 64'(in_rdy), 64'd1);
    run_to_done(40);
    check("bc_accepts", 64'(n_accept), 64'd5);
    check("bc_back_to_back", 64'(last_acc - first_acc), 64'd4);
    check("bc_done_after_last_pop", 64'(done_cyc - last_pop), 64'd1);
    check_drained("bc");
    tick();
    check("bc_done_one_cycle", 64'(done), 64'd0);

    $display("[TB] distribute mask=101 len=3");
    start_job(1'b1, 3'b101, 10'd3);
    expect_row(0, 0, 3);
    expect_row(2, 3, 3);
    run_to_done(40);
    check("dist_accepts", 64'(n_accept), 64'd6);
    check("dist_row1_quiet", 64'(vld_seen[1]), 64'd0);
    check_drained("dist");

    $display("[TB] broadcast with row 1 stalled");
    start_job(1'b0, 3'b111, 10'd10);
    for (int r = 0; r < N_ROW; r++) expect_row(r, 0, 10);
    act_data_in_req = 3'b101;
    for (int i = 0; i < 20; i++) tick();
    check("stall_accepts", 64'(n_accept), 64'd4);
    check("stall_rdy_low", 64'(in_rdy), 64'd0);
    check("stall_busy", 64'(busy), 64'd1);
    check("stall_row1_vld", 64'(act_data_in_vld[1]), 64'd1);
    act_data_in_req = 3'b111;
    run_to_done(60);
    check("stall_total_accepts", 64'(n_accept), 64'd10);
    check_drained("stall");

    $display("[TB] degenerate starts");
    start_job(1'b0, 3'b111, 10'd0);
    check("len0_done", 64'(done), 64'd1);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_rdy", 64'(in_rdy), 64'd0);
    tick();
    check("len0_done_clear", 64'(done), 64'd0);
    check("len0_no_accept", 64'(n_accept), 64'd0);
    start_job(1'b1, 3'b000, 10'd5);
    check("mask0_done", 64'(done), 64'd1);
    check("mask0_busy", 64'(busy), 64'd0);
    check("mask0_rdy", 64'(in_rdy), 64'd0);
    tick();
    check("mask0_done_clear", 64'(done), 64'd0);
    check("mask0_no_accept", 64'(n_accept), 64'd0);

    $display("[TB] reset during FEED");
    act_data_in_req = 3'b000;
    start_job(1'b0, 3'b111, 10'd8);
    tick();
    tick();
    check("midrst_buffered", 64'(n_accept), 64'd2);
    check("midrst_vld_before", 64'(act_data_in_vld), 64'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_vld", 64'(act_data_in_vld), 64'd0);
    check("midrst_data_zero", 64'(act_data_in === '0), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rdy", 64'(in_rdy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_done", 64'(done), 64'd0);
    end
    act_data_in_req = 3'b111;
    start_job(1'b0, 3'b010, 10'd2);
    expect_row(1, 0, 2);
    run_to_done(30);
    check("postrst_accepts", 64'(n_accept), 64'd2);
    check("postrst_rows", 64'(vld_seen), 64'd2);
    check_drained("postrst");

    $display("[TB] cfg_start while busy");
    start_job(1'b1, 3'b011, 10'd2);
    expect_row(0, 0, 2);
    expect_row(1, 2, 2);
    cfg_mode = 1'b0;
    cfg_row_mask = 3'b100;
    cfg_len = 10'd7;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run_to_done(40);
    check("restart_accepts", 64'(n_accept), 64'd4);
    check("restart_row2_quiet", 64'(vld_seen[2]), 64'd0);
    check_drained("restart");

    $display("[TB] broadcast max length");
    start_job(1'b0, 3'b001, 10'd1023);
    expect_row(0, 0, 1023);
    run_to_done(1100);
    check("maxlen_accepts", 64'(n_accept), 64'd1023);
    check_drained("maxlen");

    in_vld = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
